clause_false_tracker: RTL
=========================

Name: clause_false_tracker

Overview:
- Sits directly downstream of the literal comparator.
- Accumulates, for every clause in the formula, which literals have been falsified by the variable assignments made so far.
- Each beat delivers one comparator bitmask covering one memory slice of NUM_CLAUSES_PER_CYCLE clauses. The block sweeps all slices for one assignment, then reports conflict (all literals false) and unit (exactly one literal not false) status to the solver control FSM.

Parameters:
- NUM_CLAUSES, 64, total clauses in the formula; must be a multiple of NUM_CLAUSES_PER_CYCLE.
- NUM_CLAUSES_PER_CYCLE, 16, clauses per comparator bitmask beat.
- NUM_VARS_PER_CLAUSE, 3, literals per clause.
- CLAUSE_ID_BITS, $clog2(NUM_CLAUSES), width of reported clause indices.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock.
- reset  in  1  reset is synchronous and active-high.
- clear  in  1  zero all clause state and return to IDLE.
- start  in  1  begin a sweep for one assignment; accepted only in IDLE.
- in_valid  in  1  bitmask beat valid.
- in_ready  out  1  block can accept a beat.
- in_bitmask  in  NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE  falsified-literal mask; bit c*NUM_VARS_PER_CLAUSE+l = literal l of slice-local clause c is false.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep report is valid.
- conflict  out  1  some clause has all literals false.
- conflict_id  out  CLAUSE_ID_BITS  lowest-indexed conflicting clause.
- unit_found  out  1  some non-conflicting clause has exactly one literal not false.
- unit_id  out  CLAUSE_ID_BITS  lowest-indexed unit clause.
- unit_lit  out  2  position (0..NUM_VARS_PER_CLAUSE-1) of the remaining literal in unit_id.

Behaviour:
- State: one false-mask register of NUM_VARS_PER_CLAUSE bits per clause, NUM_SLICES = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE slices, and a slice counter.
- reset: masks = 0, state IDLE, slice counter = 0. All outputs are 0: in_ready, busy, done, conflict, conflict_id, unit_found, unit_id, unit_lit.
- FSM IDLE -> SWEEP -> REPORT -> IDLE.
  - IDLE: in_ready=0. On start, go to SWEEP, set slice counter to 0, and clear conflict/unit outputs.
  - SWEEP: in_ready=1, busy=1.
    - Each cycle with in_valid&&in_ready, OR in_bitmask into the masks of clauses slice*NUM_CLAUSES_PER_CYCLE .. +NUM_CLAUSES_PER_CYCLE-1, then increment the slice counter.
    - In the same cycle, evaluate the updated masks of that slice and fold them into running conflict/unit results.
    - A lower clause index wins; slices arrive in ascending order, so keep the first hit.
    - in_valid low: hold state, no update.
  - On acceptance of beat NUM_SLICES-1, go to REPORT.
  - REPORT: done=1 for exactly one cycle, busy=0, in_ready=0, then IDLE.
- Result outputs:
  - Latency: done rises the cycle after the last beat is accepted.
  - conflict, conflict_id, unit_found, unit_id and unit_lit are valid from done and held until the next start, clear or reset.
- Unit rule: a clause is unit iff its popcount is exactly NUM_VARS_PER_CLAUSE-1; unit_lit is the index of its single 0 bit. A clause with all bits set is a conflict, never a unit.
- Masks are sticky across sweeps; only clear or reset zeroes them.
- start outside IDLE is ignored. in_valid outside SWEEP is ignored and has no state effect.
- clear has priority over start and over a beat in the same cycle.
  - Mid-sweep clear: zero the masks, abort to IDLE, no done pulse.
  - Conflict/unit outputs are zeroed.
- reset overrides everything, including clear.
- A re-falsified literal (bit already set) is idempotent.

Optional Feature:
- Macro CLAUSE_FALSE_TRACKER_UNIT_EN.
- Defined: unit detection exactly as above.
- Undefined: no popcount/priority logic for units; unit_found, unit_id and unit_lit are tied to 0. Conflict behaviour is unchanged.

Test Plan:
- Reset, then start and 4 beats of all-zero masks -> in_ready high for exactly 4 accepted beats; done one cycle after beat 3; conflict=0, unit_found=0.
- Sweep 1: slice 0 beat with bits 0,1 set (clause 0, literals 0,1 false) -> unit_found=1, unit_id=0, unit_lit=2, conflict=0.
- Sweep 2: slice 0 beat with bit 2 set -> conflict=1, conflict_id=0. Clause 0 is no longer unit; unit_found=0 unless another clause qualifies.
- Slice 2 beat with bits for clauses 35 and 40 each having 2 literals false -> unit_id=35 (lowest wins).
- Start, 2 beats accepted, then in_valid toggled low for 3 cycles -> no progress; after 2 more beats, done fires. Repeat with clear asserted after beat 1 -> IDLE, no done, all masks 0 on the following sweep.
- Build without CLAUSE_FALSE_TRACKER_UNIT_EN, repeat scenario 2 -> unit_found=0, unit_id=0, unit_lit=0; conflict results identical to the default build.

Source files
------------

// File: rtl/clause_false_tracker_if.sv
// clause_false_tracker_if: comparator-to-tracker beat channel.
//   in_valid   : beat valid (master -> slave)
//   in_ready   : tracker can accept a beat (slave -> master)
//   in_bitmask : falsified-literal mask, bit c*NUM_VARS_PER_CLAUSE+l is
//                literal l of slice-local clause c (master -> slave)
interface clause_false_tracker_if #(
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  parameter int NUM_CLAUSES_PER_CYCLE = 16
);
  logic                                                 in_valid;
  logic                                                 in_ready;
  logic [NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE-1:0] in_bitmask;

  modport master (output in_valid, output in_bitmask, input in_ready);
  modport slave  (input in_valid, input in_bitmask, output in_ready);
endinterface

// File: rtl/clause_false_tracker.sv
// clause_false_tracker: accumulates per-clause falsified-literal masks from
// comparator beats (one memory slice per beat), sweeps all slices for one
// assignment, then reports the lowest conflicting clause and the lowest unit
// clause.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : zero all clause masks and results, return to IDLE
//   start        : begin a sweep (IDLE only)
//   in_if        : beat channel (in_valid / in_ready / in_bitmask)
//   busy         : sweep in progress
//   done         : one-cycle pulse, report valid
//   conflict, conflict_id        : lowest clause with every literal false
//   unit_found, unit_id, unit_lit: lowest clause with exactly one literal
//                                  not false, and that literal's position
// Build option: define CLAUSE_FALSE_TRACKER_UNIT_EN to enable unit
// detection; otherwise unit_found/unit_id/unit_lit are tied to 0.
module clause_false_tracker #(
  parameter int NUM_CLAUSES           = 64,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  parameter int CLAUSE_ID_BITS        = $clog2(NUM_CLAUSES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      start,
  clause_false_tracker_if.slave     in_if,
  output logic                      busy,
  output logic                      done,
  output logic                      conflict,
  output logic [CLAUSE_ID_BITS-1:0] conflict_id,
  output logic                      unit_found,
  output logic [CLAUSE_ID_BITS-1:0] unit_id,
  output logic [1:0]                unit_lit
);

  localparam int NUM_SLICES = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int SLICE_BITS = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int P          = NUM_CLAUSES_PER_CYCLE;
  localparam int NV         = NUM_VARS_PER_CLAUSE;

  typedef logic [P-1:0][NV-1:0] slice_t;
  typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_t;

  state_t                  state, state_n;
  slice_t                  masks [NUM_SLICES];
  logic [SLICE_BITS-1:0]   slice_cnt;
  slice_t                  beat, upd;
  logic                    accept, wipe, last;
  logic [CLAUSE_ID_BITS-1:0] slice_base;
  logic                    slc_conf;
  logic [CLAUSE_ID_BITS-1:0] slc_conf_id;

  assign beat       = in_if.in_bitmask;
  assign upd        = masks[slice_cnt] | beat;
  assign last       = (slice_cnt == SLICE_BITS'(NUM_SLICES - 1));
  assign accept     = (state == SWEEP) && in_if.in_valid;
  assign wipe       = clear || ((state == IDLE) && start);
  assign slice_base = CLAUSE_ID_BITS'(32'(slice_cnt) * P);

  always_comb begin
    state_n        = state;
    in_if.in_ready = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE:   if (start) state_n = SWEEP;
      SWEEP: begin
        in_if.in_ready = 1'b1;
        busy           = 1'b1;
        if (in_if.in_valid && last) state_n = REPORT;
      end
      REPORT: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  // Lowest conflicting clause within the slice being updated this cycle.
  always_comb begin
    slc_conf    = 1'b0;
    slc_conf_id = '0;
    for (int unsigned c = 0; c < P; c++) begin
      if (!slc_conf && (&upd[c])) begin
        slc_conf    = 1'b1;
        slc_conf_id = slice_base + CLAUSE_ID_BITS'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      masks       <= '{default: '0};
      slice_cnt   <= '0;
      conflict    <= 1'b0;
      conflict_id <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        masks       <= '{default: '0};
        slice_cnt   <= '0;
        conflict    <= 1'b0;
        conflict_id <= '0;
      end else if (wipe) begin
        slice_cnt   <= '0;
        conflict    <= 1'b0;
        conflict_id <= '0;
      end else if (accept) begin
        masks[slice_cnt] <= upd;
        slice_cnt        <= last ? '0 : slice_cnt + 1'b1;
        // Slices arrive in ascending order, so the first hit is the lowest.
        if (!conflict && slc_conf) begin
          conflict    <= 1'b1;
          conflict_id <= slc_conf_id;
        end
      end
    end
  end

`ifdef CLAUSE_FALSE_TRACKER_UNIT_EN
  logic                      slc_unit;
  logic [CLAUSE_ID_BITS-1:0] slc_unit_id;
  logic [1:0]                slc_unit_lit;
  int unsigned               pc;
  logic [1:0]                zl;

  // A unit clause has popcount NV-1; zl captures its single clear bit.
  always_comb begin
    slc_unit     = 1'b0;
    slc_unit_id  = '0;
    slc_unit_lit = '0;
    pc           = 0;
    zl           = '0;
    for (int unsigned c = 0; c < P; c++) begin
      pc = 0;
      zl = '0;
      for (int unsigned l = 0; l < NV; l++) begin
        if (upd[c][l]) pc = pc + 1;
        else           zl = 2'(l);
      end
      if (!slc_unit && (pc == NV - 1)) begin
        slc_unit     = 1'b1;
        slc_unit_id  = slice_base + CLAUSE_ID_BITS'(c);
        slc_unit_lit = zl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || wipe) begin
      unit_found <= 1'b0;
      unit_id    <= '0;
      unit_lit   <= '0;
    end else if (accept && !unit_found && slc_unit) begin
      unit_found <= 1'b1;
      unit_id    <= slc_unit_id;
      unit_lit   <= slc_unit_lit;
    end
  end
`else
  assign unit_found = 1'b0;
  assign unit_id    = '0;
  assign unit_lit   = '0;
`endif

endmodule
